// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode, next-PC source and halt-sequence definitions
package rv_ctrl_pkg;

  localparam logic [6:0] OP_JAL   = 7'b110_1111;
  localparam logic [6:0] OP_JALR  = 7'b110_0111;
  localparam logic [6:0] OP_BR    = 7'b110_0011;
  localparam logic [6:0] OP_LD    = 7'b000_0011;
  localparam logic [6:0] OP_SW    = 7'b010_0011;
  localparam logic [6:0] OP_ITYPE = 7'b001_0011;
  localparam logic [6:0] OP_RTYPE = 7'b011_0011;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_JALR   = 2'b01,
    PCSRC_ALUOUT = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  // addi x1,x0,12 followed by jalr x0,0(x1) marks end of program
  localparam logic [31:0] HALT_W0 = 32'h00c0_0093;
  localparam logic [31:0] HALT_W1 = 32'h0000_8067;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    ARMED  = 2'b01,
    HALTED = 2'b10
  } halt_state_e;

endpackage

// File: rtl/halt_detect.sv
// rtl/halt_detect.sv - watches latched instruction words for the two-word halt sequence
module halt_detect
  import rv_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        strobe,
  input  logic [31:0] data,
  output logic        HALT
);

  halt_state_e r_state;
  halt_state_e w_next;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (strobe) begin
      unique case (r_state)
        RUN: begin
          if (data == HALT_W0) w_next = ARMED;
        end
        ARMED: begin
          if (data == HALT_W1)      w_next = HALTED;
          else if (data == HALT_W0) w_next = ARMED;
          else                      w_next = RUN;
        end
        HALTED:  w_next = HALTED;
        default: w_next = RUN;
      endcase
    end
  end

  assign HALT = (r_state == HALTED);

endmodule

// File: rtl/pc_ir_unit.sv
// rtl/pc_ir_unit.sv - PC, instruction register, fetch PC and fetch counter of the multicycle core
module pc_ir_unit
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               PC_WR,
  input  logic               PC_WRITE_COND,
  input  logic               BR_TAKEN,
  input  logic [1:0]         MUX4,
  input  logic [31:0]        ALU_RESULT,
  input  logic [31:0]        ALU_OUT,
  input  logic               IR_WR,
  input  logic [31:0]        I_MEM_DI,
  output logic [IMEM_AW-1:0] I_MEM_ADDR,
  output logic [31:0]        PC,
  output logic [31:0]        OLD_PC,
  output logic [31:0]        IR,
  output logic [6:0]         OPCODE,
  output logic [31:0]        INST_CNT,
  output logic               MISALIGN,
  output logic               HALT
);

  logic [31:0] r_pc;
  logic [31:0] r_old_pc;
  logic [31:0] r_ir;
  logic [31:0] r_inst_cnt;
  logic        r_misalign;

  logic        w_halt;
  logic        w_pc_en;
  logic        w_ir_en;
  logic        w_pc_src_live;
  logic        w_bad_target;
  logic [31:0] w_next_pc;

  // Once halted, every controller strobe is masked at the source
  assign w_pc_en = ~w_halt & (PC_WR | (PC_WRITE_COND & BR_TAKEN));
  assign w_ir_en = ~w_halt & IR_WR;

  always_comb begin
    w_next_pc = r_pc;
    unique case (MUX4)
      PCSRC_ALU:    w_next_pc = ALU_RESULT;
      PCSRC_JALR:   w_next_pc = {ALU_RESULT[31:1], 1'b0};
      PCSRC_ALUOUT: w_next_pc = ALU_OUT;
      default:      w_next_pc = r_pc;
    endcase
  end

  assign w_pc_src_live = w_pc_en & (MUX4 != PCSRC_HOLD);
  assign w_bad_target  = w_pc_src_live & (w_next_pc[1:0] != 2'b00);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pc       <= RESET_PC;
      r_old_pc   <= RESET_PC;
      r_ir       <= 32'h0;
      r_inst_cnt <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      if (w_pc_src_live && !w_bad_target) r_pc <= w_next_pc;
      if (w_bad_target) r_misalign <= 1'b1;
      if (w_ir_en) begin
        r_ir       <= I_MEM_DI;
        r_old_pc   <= r_pc;
        r_inst_cnt <= r_inst_cnt + 32'd1;
      end
    end
  end

  halt_detect u_halt_detect (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .strobe (w_ir_en),
    .data   (I_MEM_DI),
    .HALT   (w_halt)
  );

  assign I_MEM_ADDR = r_pc[IMEM_AW+1:2];
  assign PC         = r_pc;
  assign OLD_PC     = r_old_pc;
  assign IR         = r_ir;
  assign OPCODE     = r_ir[6:0];
  assign INST_CNT   = r_inst_cnt;
  assign MISALIGN   = r_misalign;
  assign HALT       = w_halt;

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb/tb_pc_ir_unit.sv - directed and randomized self-checking bench for pc_ir_unit
module tb_pc_ir_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] W0     = 32'h00c0_0093;
  localparam logic [31:0] W1     = 32'h0000_8067;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        PC_WR, PC_WRITE_COND, BR_TAKEN, IR_WR;
  logic [1:0]  MUX4;
  logic [31:0] ALU_RESULT, ALU_OUT, I_MEM_DI;
  logic [11:0] I_MEM_ADDR;
  logic [31:0] PC, OLD_PC, IR, INST_CNT;
  logic [6:0]  OPCODE;
  logic        MISALIGN, HALT;

  pc_ir_unit #(.RESET_PC(RST_PC), .IMEM_AW(12)) dut (
    .CLK(CLK), .RSTn(RSTn), .PC_WR(PC_WR), .PC_WRITE_COND(PC_WRITE_COND),
    .BR_TAKEN(BR_TAKEN), .MUX4(MUX4), .ALU_RESULT(ALU_RESULT), .ALU_OUT(ALU_OUT),
    .IR_WR(IR_WR), .I_MEM_DI(I_MEM_DI), .I_MEM_ADDR(I_MEM_ADDR), .PC(PC),
    .OLD_PC(OLD_PC), .IR(IR), .OPCODE(OPCODE), .INST_CNT(INST_CNT),
    .MISALIGN(MISALIGN), .HALT(HALT)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_old, m_ir, m_cnt, m_last;
  bit          m_mis, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_old = RST_PC; m_ir = 32'h0; m_cnt = 32'h0;
    m_last = 32'h0; m_mis = 1'b0; m_halt = 1'b0;
  endtask

  // Reference: halt fires when an accepted W1 directly follows an accepted W0
  task automatic model_edge();
    logic [31:0] tgt, n_pc;
    bit en;
    if (!m_halt) begin
      n_pc = m_pc;
      en = PC_WR || (PC_WRITE_COND && BR_TAKEN);
      if (en && MUX4 != 2'd3) begin
        if (MUX4 == 2'd0)      tgt = ALU_RESULT;
        else if (MUX4 == 2'd1) tgt = (ALU_RESULT / 2) * 2;
        else                   tgt = ALU_OUT;
        if (tgt % 4 != 0) m_mis = 1'b1;
        else              n_pc = tgt;
      end
      if (IR_WR) begin
        m_old = m_pc;
        m_ir  = I_MEM_DI;
        m_cnt = m_cnt + 1;
        if (m_last == W0 && I_MEM_DI == W1) m_halt = 1'b1;
        m_last = I_MEM_DI;
      end
      m_pc = n_pc;
    end
  endtask

  task automatic check_all();
    chk("pc", PC, m_pc);
    chk("imem_addr", {20'h0, I_MEM_ADDR}, {20'h0, m_pc[13:2]});
    chk("old_pc", OLD_PC, m_old);
    chk("ir", IR, m_ir);
    chk("opcode", {25'h0, OPCODE}, {25'h0, m_ir[6:0]});
    chk("inst_cnt", INST_CNT, m_cnt);
    chk("misalign", {31'h0, MISALIGN}, {31'h0, m_mis});
    chk("halt", {31'h0, HALT}, {31'h0, m_halt});
  endtask

  task automatic idle();
    PC_WR = 0; PC_WRITE_COND = 0; BR_TAKEN = 0; IR_WR = 0; MUX4 = 2'b11;
    ALU_RESULT = 0; ALU_OUT = 0; I_MEM_DI = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt_before, rnd;
    int sel;
    idle();
    RSTn = 1'b0;
    model_reset();
    #13;
    check_all();
    RSTn = 1'b1;

    step();
    chk("rst_pc_const", PC, 32'h100);
    chk("rst_addr_const", {20'h0, I_MEM_ADDR}, 32'h040);

    IR_WR = 1; I_MEM_DI = 32'h0000_0013; PC_WR = 1; MUX4 = 2'b00; ALU_RESULT = 32'h104;
    step();
    chk("fetch_pc_const", PC, 32'h104);
    chk("fetch_old_const", OLD_PC, 32'h100);
    idle();

    PC_WRITE_COND = 1; BR_TAKEN = 0; ALU_OUT = 32'h200; MUX4 = 2'b10;
    step();
    chk("br_not_taken", PC, 32'h104);
    BR_TAKEN = 1;
    step();
    chk("br_taken", PC, 32'h200);
    idle();

    PC_WR = 1; MUX4 = 2'b01; ALU_RESULT = 32'h301;
    step();
    chk("jalr_pc", PC, 32'h300);
    MUX4 = 2'b00; ALU_RESULT = 32'h302;
    step();
    chk("misalign_pc", PC, 32'h300);
    chk("misalign_flag", {31'h0, MISALIGN}, 32'h1);
    PC_WR = 1; MUX4 = 2'b11; ALU_RESULT = 32'h400;
    step();
    idle();

    cnt_before = m_cnt;
    foreach (seq_words[k]) begin
      IR_WR = 1; I_MEM_DI = seq_words[k];
      step();
      if (k < 4) chk("no_early_halt", {31'h0, HALT}, 32'h0);
    end
    idle();
    chk("halt_set", {31'h0, HALT}, 32'h1);
    chk("halt_cnt", INST_CNT - cnt_before, 32'd5);
    chk("halt_ir", IR, W1);

    PC_WR = 1; MUX4 = 2'b00; ALU_RESULT = 32'h500; IR_WR = 1; I_MEM_DI = 32'hdead_beef;
    repeat (3) step();
    idle();

    @(negedge CLK);
    #2;
    RSTn = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst_pc", PC, RST_PC);
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 39) apply_reset();
      PC_WR = ($urandom_range(0, 3) == 0);
      PC_WRITE_COND = $urandom_range(0, 1);
      BR_TAKEN = $urandom_range(0, 1);
      MUX4 = $urandom_range(0, 3);
      rnd = $urandom;
      ALU_RESULT = ($urandom_range(0, 5) == 0) ? rnd : {rnd[31:2], 2'b00};
      rnd = $urandom;
      ALU_OUT = ($urandom_range(0, 5) == 0) ? rnd : {rnd[31:2], 2'b00};
      IR_WR = $urandom_range(0, 1);
      sel = $urandom_range(0, 5);
      I_MEM_DI = (sel == 0) ? W0 : (sel == 1) ? W1 : $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  logic [31:0] seq_words [5] = '{32'h00c0_0093, 32'h0000_0013, 32'h00c0_0093,
                                 32'h00c0_0093, 32'h0000_8067};

endmodule
